tc_mult_arbiter: RTL and testbench

Shared-multiplier scheduler for the TrackletCalculator: several requesters contend for a single pipelined 17-bit signed × 10-bit unsigned multiplier, the L1L2 tracklet product path. A round-robin arbiter grants one request per cycle, and the block tags it with the requester id. Results return in issue order on one result port with valid/ready backpressure. Its purpose is to let several calculator stages share one DSP slice in place of one multiplier each.

---
 rtl/tc_mult_pkg.sv | 24 ++
 rtl/tc_mult_rr_arbiter.sv | 38 +++
 rtl/tc_mult_arbiter.sv | 156 +++++++++++++++
 tb/tb_tc_mult_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_mult_pkg.sv
// Shared widths and the product helper for the shared TrackletCalculator multiplier.
// The package is used by tc_mult_rr_arbiter and by tc_mult_arbiter.
package tc_mult_pkg;

   localparam int A_W    = 17;   // signed operand a
   localparam int B_W    = 10;   // unsigned operand b
   localparam int P_W    = 26;   // product width; wider results wrap
   localparam int STAT_W = 16;   // statistics counter width

   // Low P_W bits of signed(a) * signed({1'b0,b}).
   // The low P_W bits of a product depend only on the low P_W bits of each
   // operand. Extending both operands to P_W (a sign-extended, b zero-extended)
   // and keeping a P_W-bit product therefore gives the same wrapped result as
   // the full-width signed multiply.
   function automatic logic [P_W-1:0] mul_p(input logic [A_W-1:0] a,
                                            input logic [B_W-1:0] b);
      logic [P_W-1:0] a_ext;
      logic [P_W-1:0] b_ext;
      a_ext = {{(P_W-A_W){a[A_W-1]}}, a};
      b_ext = {{(P_W-B_W){1'b0}}, b};
      return a_ext * b_ext;
   endfunction

endpackage

// File: rtl/tc_mult_rr_arbiter.sv
// Round-robin arbiter for tc_mult_arbiter.
// The search starts one position past the pointer. The grant is gated by the
// enable input; the encoded index is always the search winner.
module tc_mult_rr_arbiter
   import tc_mult_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic                    en_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         grant_o,
   output logic [$clog2(NREQ)-1:0] idx_o
);

   localparam int ID_W = $clog2(NREQ);

   // Find the first valid request at (ptr+1), (ptr+2), ... with wraparound
   always_comb begin
      logic            found;
      logic [ID_W-1:0] cand;
      found   = 1'b0;
      cand    = '0;
      grant_o = '0;
      idx_o   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = ID_W'((int'(ptr_i) + k) % NREQ);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = cand;
         end
      end
      if (found && en_i) begin
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/tc_mult_arbiter.sv
// Shared multiplier scheduler. Several requesters share one pipelined
// 17x10 signed*unsigned multiplier. Results return in grant order and carry
// the id and tag of the requester.
// Optional statistics counters are built only when TC_MULT_ARB_STATS_EN is
// defined. Otherwise the stat ports are tied to zero.
module tc_mult_arbiter
   import tc_mult_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int LAT   = 3,
   parameter int TAG_W = 7
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*A_W-1:0]       req_a,
   input  logic [NREQ*B_W-1:0]       req_b,
   input  logic [NREQ*TAG_W-1:0]     req_tag,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [$clog2(NREQ)-1:0]   res_id,
   output logic [TAG_W-1:0]          res_tag,
   output logic [P_W-1:0]            res_p,
   output logic [NREQ*STAT_W-1:0]    stat_grant_cnt,
   output logic [STAT_W-1:0]         stat_stall_cnt
);

   localparam int ID_W = $clog2(NREQ);

   // One pipeline stage. The product is formed when the request enters
   // stage 0, and the later stages only delay it.
   typedef struct packed {
      logic             valid;
      logic [ID_W-1:0]  id;
      logic [TAG_W-1:0] tag;
      logic [P_W-1:0]   p;
   } stage_t;

   logic            en;
   logic [NREQ-1:0] grant;
   logic [ID_W-1:0] grant_idx;
   logic            hs_any;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [A_W-1:0]  a_sel;
   logic [B_W-1:0]  b_sel;
   logic [TAG_W-1:0] tag_sel;
   stage_t          stage_in_d;
   stage_t          stage_q [LAT];

   // The whole pipeline freezes while a result waits for the consumer.
   assign en = !(res_valid && !res_ready);

   tc_mult_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i   (req_valid),
      .en_i    (en),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx)
   );

   // No grants while reset is held.
   assign req_ready = grant & {NREQ{ap_rst_n}};
   assign hs_any    = |req_ready;

   assign a_sel   = req_a[int'(grant_idx)*A_W +: A_W];
   assign b_sel   = req_b[int'(grant_idx)*B_W +: B_W];
   assign tag_sel = req_tag[int'(grant_idx)*TAG_W +: TAG_W];

   // Build the record that enters stage 0: the granted request, or a bubble.
   always_comb begin
      stage_in_d = '0;
      if (hs_any) begin
         stage_in_d.valid = 1'b1;
         stage_in_d.id    = grant_idx;
         stage_in_d.tag   = tag_sel;
         stage_in_d.p     = mul_p(a_sel, b_sel);
      end
   end

   // The pointer moves to the winner on a handshake and holds otherwise.
   always_comb begin
      ptr_d = ptr_q;
      if (hs_any) begin
         ptr_d = grant_idx;
      end
   end

   // Pointer register. After reset it points at NREQ-1, so requester 0 is
   // searched first.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ptr_q <= ID_W'(NREQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

   for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
         // Stage 0 captures the product of the granted operands.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               stage_q[gi] <= '0;
            end else if (en) begin
               stage_q[gi] <= stage_in_d;
            end
         end
      end else begin : g_delay
         // Delay stages let synthesis retime the product into the DSP.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               stage_q[gi] <= '0;
            end else if (en) begin
               stage_q[gi] <= stage_q[gi-1];
            end
         end
      end
   end

   assign res_valid = stage_q[LAT-1].valid;
   assign res_id    = stage_q[LAT-1].id;
   assign res_tag   = stage_q[LAT-1].tag;
   assign res_p     = stage_q[LAT-1].p;

`ifdef TC_MULT_ARB_STATS_EN
   logic [STAT_W-1:0] grant_cnt_q [NREQ];
   logic [STAT_W-1:0] stall_cnt_q;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant_cnt
      // Count accepted requests per requester. The counter wraps at 0xFFFF.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            grant_cnt_q[gi] <= '0;
         end else if (req_ready[gi]) begin
            grant_cnt_q[gi] <= grant_cnt_q[gi] + STAT_W'(1);
         end
      end
      assign stat_grant_cnt[gi*STAT_W +: STAT_W] = grant_cnt_q[gi];
   end

   // Count cycles where a result is blocked by the consumer.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         stall_cnt_q <= '0;
      end else if (res_valid && !res_ready) begin
         stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
   end
   assign stat_stall_cnt = stall_cnt_q;
`else
   assign stat_grant_cnt = '0;
   assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tc_mult_arbiter.sv
// Self-checking bench for tc_mult_arbiter with NREQ=4, LAT=3 and TAG_W=7.
// Stimulus pushes the expected results into a queue. A monitor pops an entry
// and compares it on every result handshake.
module tb_tc_mult_arbiter;

   localparam int NREQ  = 4;
   localparam int LAT   = 3;
   localparam int TAG_W = 7;

   typedef struct packed {
      logic [1:0]  id;
      logic [6:0]  tag;
      logic [25:0] p;
   } exp_t;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [67:0] req_a = '0;
   logic [39:0] req_b = '0;
   logic [27:0] req_tag = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [1:0]  res_id;
   logic [6:0]  res_tag;
   logic [25:0] res_p;
   logic [63:0] stat_grant_cnt;
   logic [15:0] stat_stall_cnt;

   int   errors = 0;
   int   checks = 0;
   bit   quiet  = 1'b0;
   exp_t exp_q[$];
   exp_t got_e, exp_e;

   tc_mult_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_tag        (req_tag),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_id         (res_id),
      .res_tag        (res_tag),
      .res_p          (res_p),
      .stat_grant_cnt (stat_grant_cnt),
      .stat_stall_cnt (stat_stall_cnt)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic set_req(input int i, input logic [16:0] a, input logic [9:0] b,
                          input logic [6:0] tag);
      req_a[i*17 +: 17]  = a;
      req_b[i*10 +: 10]  = b;
      req_tag[i*7 +: 7]  = tag;
      req_valid[i]       = 1'b1;
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Hold reset across a clock edge, then release it mid-cycle.
   task automatic do_reset();
      ap_rst_n = 1'b0;
      tick();
      ap_rst_n = 1'b1;
   endtask

   // Wait, with a bound, for requester i to be granted. Drop its valid after the handshake edge.
   task automatic issue_wait(input int i);
      bit done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
         #1;
         if (req_ready[i]) begin
            tick();
            req_valid[i] = 1'b0;
            done = 1'b1;
         end else begin
            @(posedge ap_clk);
         end
      end
      if (!done) chk("grant_timeout", 64'(req_ready), 64'(1 << i));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: compare each accepted result with the oldest expected entry.
   always @(negedge ap_clk) begin
      if (ap_rst_n && res_valid && res_ready) begin
         got_e = {res_id, res_tag, res_p};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got id=%0d tag=%0d p=%0h, expected none",
                     res_id, res_tag, res_p);
         end else begin
            exp_e = exp_q.pop_front();
            if (got_e !== exp_e) begin
               errors++;
               $display("FAIL result: got id=%0d tag=%0d p=%0h, expected id=%0d tag=%0d p=%0h",
                        res_id, res_tag, res_p, exp_e.id, exp_e.tag, exp_e.p);
            end else if (!quiet) begin
               $display("result id=%0d tag=%0d p=%0h ok", res_id, res_tag, res_p);
            end
         end
      end
   end

   initial begin
      int lat;
      logic [34:0] frozen;

      // Reset state, with every requester asserting valid.
      req_valid = 4'hF;
      #2;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_fields", 64'({res_id, res_tag, res_p}), 64'd0);
      chk("rst_stats", 64'({stat_grant_cnt, stat_stall_cnt}), 64'd0);
      req_valid = '0;
      tick();
      ap_rst_n = 1'b1;
      tick();

      // Single request from requester 2, and its latency.
      set_req(2, 17'sd100, 10'd3, 7'd5);
      exp_q.push_back({2'd2, 7'd5, 26'd300});
      #1;
      chk("single_ready", 64'(req_ready), 64'b0100);
      tick();
      req_valid[2] = 1'b0;
      #1;
      chk("single_ready_drop", 64'(req_ready), 64'd0);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (res_valid) begin
            lat = n;
            break;
         end
      end
      chk("latency", 64'(lat), 64'(LAT - 1));
      drain();

      // a=-1, b=1 gives -1 in 26 bits.
      set_req(1, -17'sd1, 10'd1, 7'd3);
      exp_q.push_back({2'd1, 7'd3, 26'h3FFFFFF});
      issue_wait(1);
      drain();

      // Round robin with all four valid for 8 cycles after reset.
      do_reset();
      set_req(0, -17'sd3,    10'd7,    7'd8);
      set_req(1, 17'sd200,   10'd1023, 7'd9);
      set_req(2, 17'h10000,  10'd1023, 7'd10);   // a = -65536
      set_req(3, 17'sd65535, 10'd1023, 7'd11);
      for (int k = 0; k < 8; k++) begin
         case (k % 4)
            0: exp_q.push_back({2'd0, 7'd8,  26'h3FFFFEB});   // -21
            1: exp_q.push_back({2'd1, 7'd9,  26'd204600});
            2: exp_q.push_back({2'd2, 7'd10, 26'h0010000});   // -65536*1023 mod 2^26
            default: exp_q.push_back({2'd3, 7'd11, 26'h3FEFC01}); // 65535*1023 mod 2^26
         endcase
      end
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
         @(posedge ap_clk);
      end
      #1;
      req_valid = '0;
      drain();

      // Backpressure: 5 stall cycles while 3 results are in flight.
      do_reset();
      res_ready = 1'b0;
      set_req(0, 17'sd12, 10'd12,  7'd20);
      set_req(1, -17'sd7, 10'd100, 7'd21);
      set_req(3, 17'sd1,  10'd1023, 7'd22);
      exp_q.push_back({2'd0, 7'd20, 26'd144});
      exp_q.push_back({2'd1, 7'd21, 26'h3FFFD44});   // -700
      exp_q.push_back({2'd3, 7'd22, 26'd1023});
      #1;
      chk("bp_grant0", 64'(req_ready), 64'b0001);
      tick(); req_valid[0] = 1'b0;
      #1;
      chk("bp_grant1", 64'(req_ready), 64'b0010);
      tick(); req_valid[1] = 1'b0;
      #1;
      chk("bp_grant3", 64'(req_ready), 64'b1000);
      tick(); req_valid[3] = 1'b0;
      lat = 0;
      for (int n = 0; n < 10 && !res_valid; n++) begin
         tick();
         lat++;
      end
      chk("bp_res_valid", 64'(res_valid), 64'd1);
      set_req(2, -17'sd2, 10'd0, 7'd23);
      exp_q.push_back({2'd2, 7'd23, 26'd0});
      frozen = {res_id, res_tag, res_p};
      for (int n = 0; n < 5; n++) begin
         #1;
         chk($sformatf("bp_ready_zero%0d", n), 64'(req_ready), 64'd0);
         chk($sformatf("bp_frozen%0d", n), 64'({res_valid, res_id, res_tag, res_p}),
             64'({1'b1, frozen}));
         @(posedge ap_clk);
      end
      #1;
      res_ready = 1'b1;
      issue_wait(2);
      drain();
`ifdef TC_MULT_ARB_STATS_EN
      chk("stat_stall", 64'(stat_stall_cnt), 64'd5);
      chk("stat_grants", stat_grant_cnt, {16'd1, 16'd1, 16'd1, 16'd1});
`else
      chk("stat_stall_off", 64'(stat_stall_cnt), 64'd0);
      chk("stat_grants_off", stat_grant_cnt, 64'd0);
`endif

      // Reset mid-operation with 2 results in flight.
      set_req(0, 17'sd9, 10'd9, 7'd40);
      set_req(1, 17'sd8, 10'd8, 7'd41);
      tick(); req_valid[0] = 1'b0;
      tick(); req_valid[1] = 1'b0;
      req_valid[3] = 1'b1;
      ap_rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", 64'(res_valid), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      req_valid[3] = 1'b0;
      tick();
      ap_rst_n = 1'b1;
      lat = 0;
      for (int n = 0; n < LAT + 4; n++) begin
         tick();
         if (res_valid) lat++;
      end
      chk("midrst_no_results", 64'(lat), 64'd0);
      set_req(0, 17'sd3, 10'd4, 7'd30);
      set_req(3, 17'sd5, 10'd5, 7'd31);
      exp_q.push_back({2'd0, 7'd30, 26'd12});
      exp_q.push_back({2'd3, 7'd31, 26'd25});
      #1;
      chk("postrst_prio0", 64'(req_ready), 64'b0001);
      issue_wait(0);
      issue_wait(3);
      drain();

`ifdef TC_MULT_ARB_STATS_EN
      // Requester 1 granted 65537 times, so its counter wraps to 1.
      do_reset();
      quiet = 1'b1;
      for (int n = 0; n < 65537; n++) exp_q.push_back({2'd1, 7'd9, 26'd30});
      set_req(1, 17'sd5, 10'd6, 7'd9);
      for (int n = 0; n < 65537; n++) @(posedge ap_clk);
      #1;
      req_valid[1] = 1'b0;
      drain();
      quiet = 1'b0;
      chk("stat_wrap", 64'(stat_grant_cnt[31:16]), 64'd1);
`else
      chk("stat_final_off", 64'({stat_grant_cnt, stat_stall_cnt}), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
